ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 217 +++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for a small 9-bit instruction set.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
// sequences the ALU, register file and data memory strobes. The sequencer
// stops in HALT when it fetches HALT_WORD. It starts from PC=0 on Start.
//
// Parameters
//   PC_W       program-counter width
//   HALT_WORD  instruction word that stops execution
//
// Ports
//   CLK         in   clock, all state updates on the rising edge
//   Reset       in   asynchronous active-high reset
//   Start       in   begin execution at PC=0 (honoured in IDLE and HALT only)
//   Instr       in   fetched word: [8:7] op, [6:5] func, [4:3] RegA, [2:0] RegB/imm
//   InstrValid  in   instruction memory ack, Instr valid this cycle
//   Zero        in   ALU zero flag (beq condition)
//   MemReady    in   data memory has finished the current access
//   InstrReq    out  fetch request
//   PC          out  current instruction address
//   ALUOp       out  ALU op field
//   ALUFunc     out  ALU function field
//   Immediate   out  ALU immediate, also the RegB address
//   RegA        out  register-file address A
//   RegWrEn     out  register write strobe
//   MemRd       out  data memory read strobe
//   MemWr       out  data memory write strobe
//   Done        out  program halted
//   CycleCount  out  execution cycle count
//
// Optional feature
//   CTRL_SEQ_CYCLE_CNT_EN  when defined, CycleCount counts the cycles spent
//                          outside IDLE and HALT. It saturates at 16'hFFFF and
//                          clears on an accepted Start. When undefined,
//                          CycleCount is tied to zero.

module ctrl_seq #(
  parameter int unsigned PC_W      = 8,
  parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instr,
  input  logic            InstrValid,
  input  logic            Zero,
  input  logic            MemReady,
  output logic            InstrReq,
  output logic [PC_W-1:0] PC,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ALUFunc,
  output logic [2:0]      Immediate,
  output logic [1:0]      RegA,
  output logic            RegWrEn,
  output logic            MemRd,
  output logic            MemWr,
  output logic            Done,
  output logic [15:0]     CycleCount
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;

  // Instruction fields and classes, all taken from the latched IR.
  logic [1:0]      ir_op;
  logic [1:0]      ir_fn;
  logic            is_beq;
  logic            is_sw;
  logic            is_lw;
  logic            is_halt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_branch;

  assign ir_op   = ir_q[8:7];
  assign ir_fn   = ir_q[6:5];
  assign is_beq  = (ir_op == 2'b00) && (ir_fn == 2'b01);
  assign is_sw   = (ir_op == 2'b01) && (ir_fn == 2'b00);
  assign is_lw   = (ir_op == 2'b01) && (ir_fn == 2'b01);
  assign is_halt = (ir_q == HALT_WORD);

  // Both adds wrap modulo 2^PC_W. The branch offset is the 3-bit immediate
  // sign-extended, so 3'b111 steps back by one.
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_branch = pc_q + PC_W'($signed(ir_q[2:0]));

  // Next-state, PC and IR.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StIdle, StHalt: begin
        if (Start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        // Wait indefinitely for the instruction memory.
        if (InstrValid) begin
          ir_d    = Instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = is_halt ? StHalt : StExec;
      end
      StExec: begin
        if (is_beq) begin
          pc_d    = Zero ? pc_branch : pc_inc;
          state_d = StFetch;
        end else if (is_sw || is_lw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        // A store retires here. A load goes on to write back its data.
        if (MemReady) begin
          if (is_sw) begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        pc_d    = pc_inc;
        state_d = StFetch;
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decode only from registered state. An asynchronous reset
  // therefore clears every strobe at once, with no clock edge needed.
  logic in_body;
  assign in_body = (state_q == StDecode) || (state_q == StExec) ||
                   (state_q == StMem)    || (state_q == StWb);

  always_comb begin
    InstrReq  = (state_q == StFetch);
    MemRd     = (state_q == StMem) && is_lw;
    MemWr     = (state_q == StMem) && is_sw;
    RegWrEn   = (state_q == StWb);
    Done      = (state_q == StHalt);
    ALUOp     = 2'b00;
    ALUFunc   = 2'b00;
    Immediate = 3'b000;
    RegA      = 2'b00;
    if (in_body) begin
      ALUOp     = ir_q[8:7];
      ALUFunc   = ir_q[6:5];
      RegA      = ir_q[4:3];
      Immediate = ir_q[2:0];
    end
  end

  assign PC = pc_q;

`ifdef CTRL_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        start_go;
  logic        running;

  assign start_go = Start && ((state_q == StIdle) || (state_q == StHalt));
  assign running  = (state_q != StIdle) && (state_q != StHalt);

  always_comb begin
    cnt_d = cnt_q;
    if (start_go) begin
      cnt_d = '0;
    end else if (running && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CycleCount = cnt_q;
`else
  assign CycleCount = 16'd0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.

module tb_ctrl_seq;

  localparam logic [8:0] OrrW  = 9'b10_00_01_010;
  localparam logic [8:0] LwW   = 9'b01_01_10_011;
  localparam logic [8:0] SwW   = 9'b01_00_10_011;
  localparam logic [8:0] HaltW = 9'h1FF;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [8:0]  Instr;
  logic        InstrValid;
  logic        Zero;
  logic        MemReady;
  logic        InstrReq;
  logic [7:0]  PC;
  logic [1:0]  ALUOp;
  logic [1:0]  ALUFunc;
  logic [2:0]  Immediate;
  logic [1:0]  RegA;
  logic        RegWrEn;
  logic        MemRd;
  logic        MemWr;
  logic        Done;
  logic [15:0] CycleCount;

  int total = 0;
  int bad = 0;
  int excl_viol = 0;

  ctrl_seq dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Start      (Start),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .InstrReq   (InstrReq),
    .PC         (PC),
    .ALUOp      (ALUOp),
    .ALUFunc    (ALUFunc),
    .Immediate  (Immediate),
    .RegA       (RegA),
    .RegWrEn    (RegWrEn),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  always #5 CLK = ~CLK;

  // At most one of the four strobes may be high in any cycle.
  always @(negedge CLK) begin
    if (!Reset && $countones({InstrReq, MemRd, MemWr, RegWrEn}) > 1) excl_viol++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs n ALU instructions, starting and ending in FETCH.
  task automatic run_orr(input int n);
    for (int k = 0; k < n; k++) begin
      Instr = OrrW; InstrValid = 1'b1;
      tick();
      InstrValid = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Instr = '0; InstrValid = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    tick();
    tick();
    total++;
    if ({InstrReq, MemRd, MemWr, RegWrEn, Done, ALUOp, ALUFunc, Immediate, RegA} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h want 0",
               {InstrReq, MemRd, MemWr, RegWrEn, Done, ALUOp, ALUFunc, Immediate, RegA});
    end
    total++;
    if (PC !== 8'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", PC); end
    total++;
    if (CycleCount !== 16'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d want 0", CycleCount);
    end
    // Start is sampled on the first edge after Reset drops.
    Reset = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    total++;
    if (InstrReq !== 1'b1 || PC !== 8'd0) begin
      bad++; $display("FAIL first_start: got req=%b pc=%0d want req=1 pc=0", InstrReq, PC);
    end
  endtask

  task automatic test_orr();
    Instr = OrrW; InstrValid = 1'b1;
    tick();  // DECODE
    InstrValid = 1'b0;
    Start = 1'b1;  // must be ignored mid-instruction
    total++;
    if ({InstrReq, ALUOp, ALUFunc, RegA, Immediate} !== {1'b0, 2'b10, 2'b00, 2'b01, 3'b010}) begin
      bad++;
      $display("FAIL orr_decode: got req=%b op=%b fn=%b ra=%b imm=%b want 0 10 00 01 010",
               InstrReq, ALUOp, ALUFunc, RegA, Immediate);
    end
    tick();  // EXEC
    total++;
    if (RegWrEn !== 1'b0 || ALUOp !== 2'b10) begin
      bad++; $display("FAIL orr_exec: got wr=%b op=%b want wr=0 op=10", RegWrEn, ALUOp);
    end
    tick();  // WB
    Start = 1'b0;
    total++;
    if (RegWrEn !== 1'b1 || PC !== 8'd0) begin
      bad++; $display("FAIL orr_wb: got wr=%b pc=%0d want wr=1 pc=0", RegWrEn, PC);
    end
    tick();  // FETCH
    total++;
    if ({RegWrEn, InstrReq, ALUOp} !== 4'b0100 || PC !== 8'd1) begin
      bad++;
      $display("FAIL orr_done: got wr=%b req=%b op=%b pc=%0d want wr=0 req=1 op=00 pc=1",
               RegWrEn, InstrReq, ALUOp, PC);
    end
  endtask

  task automatic test_beq();
    logic wr_seen;
    run_orr(4);
    total++;
    if (PC !== 8'd5) begin bad++; $display("FAIL beq_setup: got pc=%0d want 5", PC); end
    for (int z = 1; z >= 0; z--) begin
      wr_seen = 1'b0;
      Instr = 9'b00_01_00_110; InstrValid = 1'b1;
      tick();  // DECODE
      InstrValid = 1'b0;
      wr_seen |= RegWrEn;
      tick();  // EXEC
      Zero = (z == 1);
      wr_seen |= RegWrEn;
      tick();  // FETCH
      Zero = 1'b0;
      wr_seen |= RegWrEn;
      total++;
      if (z == 1 && PC !== 8'd3) begin
        bad++; $display("FAIL beq_taken: got pc=%0d want 3", PC);
      end else if (z == 0 && PC !== 8'd6) begin
        bad++; $display("FAIL beq_not_taken: got pc=%0d want 6", PC);
      end
      total++;
      if (wr_seen !== 1'b0) begin bad++; $display("FAIL beq_no_write: got wr=1 want 0"); end
      if (z == 1) run_orr(2);
    end
  endtask

  task automatic test_lw();
    int rd_cnt = 0;
    Instr = LwW; InstrValid = 1'b1;
    tick();  // DECODE
    InstrValid = 1'b0;
    tick();  // EXEC
    total++;
    if (MemRd !== 1'b0) begin bad++; $display("FAIL lw_exec_rd: got 1 want 0"); end
    tick();  // MEM
    for (int i = 0; i < 4; i++) begin
      if (MemRd === 1'b1) rd_cnt++;
      MemReady = (i == 3);
      tick();
    end
    MemReady = 1'b0;
    total++;
    if (rd_cnt != 4) begin bad++; $display("FAIL lw_rd_cycles: got %0d want 4", rd_cnt); end
    total++;
    if (RegWrEn !== 1'b1 || MemRd !== 1'b0 || PC !== 8'd6) begin
      bad++;
      $display("FAIL lw_wb: got wr=%b rd=%b pc=%0d want wr=1 rd=0 pc=6", RegWrEn, MemRd, PC);
    end
    tick();  // FETCH
    total++;
    if (RegWrEn !== 1'b0 || InstrReq !== 1'b1 || PC !== 8'd7) begin
      bad++;
      $display("FAIL lw_done: got wr=%b req=%b pc=%0d want wr=0 req=1 pc=7", RegWrEn, InstrReq, PC);
    end
  endtask

  task automatic test_sw();
    int wr_cnt = 0;
    logic reg_seen = 1'b0;
    Instr = SwW; InstrValid = 1'b1;
    tick();  // DECODE
    InstrValid = 1'b0;
    tick();  // EXEC
    tick();  // MEM
    for (int i = 0; i < 4; i++) begin
      if (MemWr === 1'b1) wr_cnt++;
      reg_seen |= RegWrEn | MemRd;
      MemReady = (i == 3);
      tick();
    end
    MemReady = 1'b0;
    reg_seen |= RegWrEn;
    total++;
    if (wr_cnt != 4) begin bad++; $display("FAIL sw_wr_cycles: got %0d want 4", wr_cnt); end
    total++;
    if (reg_seen !== 1'b0) begin bad++; $display("FAIL sw_no_regwr: got 1 want 0"); end
    total++;
    if (InstrReq !== 1'b1 || MemWr !== 1'b0 || PC !== 8'd8) begin
      bad++;
      $display("FAIL sw_done: got req=%b wr=%b pc=%0d want req=1 wr=0 pc=8", InstrReq, MemWr, PC);
    end
  endtask

  task automatic test_halt();
    Instr = HaltW; InstrValid = 1'b1;
    tick();  // DECODE
    InstrValid = 1'b0;
    tick();  // HALT
    total++;
    if (Done !== 1'b1 || PC !== 8'd8 || InstrReq !== 1'b0) begin
      bad++; $display("FAIL halt_enter: got done=%b pc=%0d req=%b want 1 8 0", Done, PC, InstrReq);
    end
    tick(); tick(); tick();
    total++;
    if (Done !== 1'b1 || PC !== 8'd8 || ALUOp !== 2'b00) begin
      bad++; $display("FAIL halt_hold: got done=%b pc=%0d op=%b want 1 8 00", Done, PC, ALUOp);
    end
    Start = 1'b1;
    tick();  // FETCH
    Start = 1'b0;
    total++;
    if (Done !== 1'b0 || PC !== 8'd0 || InstrReq !== 1'b1 || CycleCount !== 16'd0) begin
      bad++;
      $display("FAIL halt_restart: got done=%b pc=%0d req=%b cnt=%0d want 0 0 1 0",
               Done, PC, InstrReq, CycleCount);
    end
    tick();
    tick();
    total++;
`ifdef CTRL_SEQ_CYCLE_CNT_EN
    if (CycleCount !== 16'd2) begin bad++; $display("FAIL cnt_run: got %0d want 2", CycleCount); end
`else
    if (CycleCount !== 16'd0) begin bad++; $display("FAIL cnt_off: got %0d want 0", CycleCount); end
`endif
  endtask

  task automatic test_reset_mid_mem();
    run_orr(1);
    Instr = LwW; InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    tick();
    tick();  // MEM, MemReady held low
    total++;
    if (MemRd !== 1'b1 || PC !== 8'd1) begin
      bad++; $display("FAIL mid_mem_setup: got rd=%b pc=%0d want 1 1", MemRd, PC);
    end
    #3;
    Reset = 1'b1;
    #1;  // well before the next rising edge
    total++;
    if ({MemRd, InstrReq, RegWrEn, Done} !== 4'b0000 || PC !== 8'd0 || ALUOp !== 2'b00) begin
      bad++;
      $display("FAIL mid_mem_reset: got rd=%b req=%b pc=%0d op=%b want 0 0 0 00",
               MemRd, InstrReq, PC, ALUOp);
    end
    tick();
    Reset = 1'b0;
    tick();
    total++;
    if (InstrReq !== 1'b0 || CycleCount !== 16'd0) begin
      bad++; $display("FAIL mid_mem_idle: got req=%b cnt=%0d want 0 0", InstrReq, CycleCount);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_pc_wrap();
    // Branch by -1 from PC=0 wraps to 255.
    Instr = 9'b00_01_00_111; InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    tick();
    Zero = 1'b1;
    tick();
    Zero = 1'b0;
    total++;
    if (PC !== 8'd255) begin bad++; $display("FAIL branch_wrap: got pc=%0d want 255", PC); end
    run_orr(1);
    total++;
    if (PC !== 8'd0) begin bad++; $display("FAIL pc_wrap: got pc=%0d want 0", PC); end
    Instr = OrrW; InstrValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({InstrReq, MemRd, MemWr, RegWrEn} !== 4'b1000 || PC !== 8'd0) begin
        bad++;
        $display("FAIL fetch_stall: got strobes=%b pc=%0d want 1000 0",
                 {InstrReq, MemRd, MemWr, RegWrEn}, PC);
      end
    end
    InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    total++;
    if (InstrReq !== 1'b0 || ALUOp !== 2'b10) begin
      bad++; $display("FAIL stall_release: got req=%b op=%b want 0 10", InstrReq, ALUOp);
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (excl_viol != 0) begin
      bad++; $display("FAIL strobe_exclusive: got %0d violations want 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_orr();
    test_beq();
    test_lw();
    test_sw();
    test_halt();
    test_reset_mid_mem();
    test_pc_wrap();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
